// File: rtl/stream_demux.sv
// Registered 1-to-NUM_OUT stream demultiplexer with one-entry output slots.
// Target is in_sel (mode 0) or a round-robin pointer (mode 1).
module stream_demux #(
  parameter  int WIDTH   = 8,
  parameter  int NUM_OUT = 8,
  localparam int SEL_W   = $clog2(NUM_OUT)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     mode,
  input  logic [WIDTH-1:0]         in_data,
  input  logic [SEL_W-1:0]         in_sel,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [NUM_OUT*WIDTH-1:0] out_data,
  output logic [NUM_OUT-1:0]       out_valid,
  input  logic [NUM_OUT-1:0]       out_ready,
  output logic [SEL_W-1:0]         rr_ptr,
  output logic [7:0]               drop_cnt
);

  localparam logic [SEL_W:0]   NUM_OUT_W = (SEL_W+1)'(NUM_OUT);
  localparam logic [SEL_W-1:0] LAST_CH   = SEL_W'(NUM_OUT - 1);

  logic [NUM_OUT-1:0]       r_valid;
  logic [NUM_OUT*WIDTH-1:0] r_data;
  logic [SEL_W-1:0]         r_ptr;
  logic [7:0]               r_drop;

  logic [SEL_W-1:0]   w_target;
  logic               w_in_range;
  logic               w_slot_free;
  logic               w_ready;
  logic               w_xfer;
  logic [NUM_OUT-1:0] w_load;

  assign w_target   = mode ? r_ptr : in_sel;
  assign w_in_range = {1'b0, w_target} < NUM_OUT_W;

  // Decode by comparison so an out-of-range select never indexes past the slots.
  always_comb begin
    w_slot_free = 1'b0;
    for (int i = 0; i < NUM_OUT; i++) begin
      if (w_target == SEL_W'(i)) begin
        w_slot_free = !r_valid[i] | out_ready[i];
      end
    end
  end

  // Out-of-range words are always accepted and discarded.
  assign w_ready = !rst & (!w_in_range | w_slot_free);
  assign w_xfer  = in_valid & w_ready;

  always_comb begin
    w_load = '0;
    for (int i = 0; i < NUM_OUT; i++) begin
      w_load[i] = w_xfer & (w_target == SEL_W'(i));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
      r_data  <= '0;
    end else begin
      for (int i = 0; i < NUM_OUT; i++) begin
        if (w_load[i]) begin
          r_valid[i]                 <= 1'b1;
          r_data[i*WIDTH +: WIDTH]   <= in_data;
        end else if (out_ready[i]) begin
          r_valid[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (w_xfer & mode) begin
      r_ptr <= (r_ptr == LAST_CH) ? '0 : r_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_drop <= '0;
    end else if (w_xfer & !w_in_range & (r_drop != 8'hFF)) begin
      r_drop <= r_drop + 8'd1;
    end
  end

  assign in_ready  = w_ready;
  assign out_data  = r_data;
  assign out_valid = r_valid;
  assign rr_ptr    = r_ptr;
  assign drop_cnt  = r_drop;

endmodule

// File: tb/tb_stream_demux.sv
// Bench for stream_demux: an 8-channel and a 5-channel instance checked every
// cycle against a slot-array reference model, with directed and random traffic.
module tb_stream_demux;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        mode0, valid0, ready0;
  logic [2:0]  sel0, ptr0;
  logic [7:0]  data0, ovalid0, oready0, drop0;
  logic [63:0] odata0;

  logic        mode1, valid1, ready1;
  logic [2:0]  sel1, ptr1;
  logic [7:0]  data1, drop1;
  logic [4:0]  ovalid1, oready1;
  logic [39:0] odata1;

  stream_demux #(.WIDTH(8), .NUM_OUT(8)) u_d8 (
    .clk(clk), .rst(rst), .mode(mode0), .in_data(data0), .in_sel(sel0),
    .in_valid(valid0), .in_ready(ready0), .out_data(odata0), .out_valid(ovalid0),
    .out_ready(oready0), .rr_ptr(ptr0), .drop_cnt(drop0)
  );

  stream_demux #(.WIDTH(8), .NUM_OUT(5)) u_d5 (
    .clk(clk), .rst(rst), .mode(mode1), .in_data(data1), .in_sel(sel1),
    .in_valid(valid1), .in_ready(ready1), .out_data(odata1), .out_valid(ovalid1),
    .out_ready(oready1), .rr_ptr(ptr1), .drop_cnt(drop1)
  );

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: one slot array per instance.
  bit         mv[2][8];
  logic [7:0] md[2][8];
  int         mptr[2];
  int         mdrop[2];
  int         nout[2] = '{8, 5};
  bit         exp_inr[2];
  int         tgt[2];

  task automatic chk(input string tag, input int d, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s[dut%0d]: observed %h expected %h", tag, d, obs, exp);
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 8; i++) begin
        mv[d][i] = 1'b0;
        md[d][i] = 8'h00;
      end
      mptr[d]  = 0;
      mdrop[d] = 0;
    end
  endtask

  task automatic get_in(input int d, output bit m, output int s, output bit v,
                        output logic [7:0] dat, output logic [7:0] ordy);
    if (d == 0) begin
      m = mode0; s = int'(sel0); v = valid0; dat = data0; ordy = oready0;
    end else begin
      m = mode1; s = int'(sel1); v = valid1; dat = data1; ordy = {3'b000, oready1};
    end
  endtask

  task automatic get_obs(input int d, output logic inr, output logic [7:0] ov,
                         output logic [63:0] od, output logic [2:0] p, output logic [7:0] dc);
    if (d == 0) begin
      inr = ready0; ov = ovalid0; od = odata0; p = ptr0; dc = drop0;
    end else begin
      inr = ready1; ov = {3'b000, ovalid1}; od = {24'h0, odata1}; p = ptr1; dc = drop1;
    end
  endtask

  // One clock cycle: check in_ready before the edge, update model, check state after.
  task automatic tick();
    bit m, v;
    int s;
    logic [7:0]  dat, ordy, ov, ev;
    logic [63:0] od, ed;
    logic        inr;
    logic [2:0]  p;
    logic [7:0]  dc;
    #1;
    for (int d = 0; d < 2; d++) begin
      get_in(d, m, s, v, dat, ordy);
      get_obs(d, inr, ov, od, p, dc);
      tgt[d] = m ? mptr[d] : s;
      exp_inr[d] = (tgt[d] >= nout[d]) ? 1'b1 : (!mv[d][tgt[d]] || ordy[tgt[d]]);
      chk("in_ready", d, 64'(inr), 64'(exp_inr[d]));
    end
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      get_in(d, m, s, v, dat, ordy);
      for (int i = 0; i < nout[d]; i++)
        if (mv[d][i] && ordy[i]) mv[d][i] = 1'b0;
      if (v && exp_inr[d]) begin
        if (tgt[d] < nout[d]) begin
          mv[d][tgt[d]] = 1'b1;
          md[d][tgt[d]] = dat;
          if (m) mptr[d] = (mptr[d] + 1) % nout[d];
        end else if (mdrop[d] < 255) begin
          mdrop[d]++;
        end
      end
    end
    #1;
    for (int d = 0; d < 2; d++) begin
      get_obs(d, inr, ov, od, p, dc);
      ev = 8'h00;
      ed = 64'h0;
      for (int i = 0; i < nout[d]; i++) begin
        ev[i]        = mv[d][i];
        ed[i*8 +: 8] = md[d][i];
      end
      chk("out_valid", d, 64'(ov), 64'(ev));
      chk("out_data", d, od, ed);
      chk("rr_ptr", d, 64'(p), 64'(mptr[d]));
      chk("drop_cnt", d, 64'(dc), 64'(mdrop[d]));
    end
    @(negedge clk);
  endtask

  task automatic idle();
    valid0 = 1'b0; valid1 = 1'b0;
    oready0 = 8'hFF; oready1 = 5'h1F;
  endtask

  initial begin
    rst = 1'b1;
    mode0 = 1'b0; sel0 = 3'd0; data0 = 8'h00;
    mode1 = 1'b0; sel1 = 3'd0; data1 = 8'h00;
    idle();
    valid0 = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 0, 64'(ready0), 64'(0));
    chk("rst_out_valid", 0, 64'(ovalid0), 64'(0));
    chk("rst_out_data", 0, odata0, 64'(0));
    chk("rst_rr_ptr", 1, 64'(ptr1), 64'(0));
    chk("rst_drop", 1, 64'(drop1), 64'(0));
    rst = 1'b0;
    idle();

    // Addressed, back-to-back into every channel.
    for (int i = 0; i < 8; i++) begin
      valid0 = 1'b1; sel0 = 3'(i); data0 = 8'hA0 + 8'(i);
      tick();
      chk("onehot", 0, 64'(ovalid0), 64'(8'h01 << i));
    end
    idle(); tick();

    // Backpressure on channel 3, channel 4 still flows.
    oready0 = 8'hF7;
    valid0 = 1'b1; sel0 = 3'd3; data0 = 8'h11; tick();
    data0 = 8'h22; tick();
    chk("bp_held", 0, 64'(odata0[31:24]), 64'(8'h11));
    sel0 = 3'd4; data0 = 8'h44; tick();
    sel0 = 3'd3; data0 = 8'h22; tick();
    oready0 = 8'hFF; tick();
    chk("bp_loaded", 0, 64'(odata0[31:24]), 64'(8'h22));
    idle(); tick();

    // Distribute on the 5-channel instance, then stall channel 2.
    mode1 = 1'b1;
    for (int k = 0; k < 12; k++) begin
      valid1 = 1'b1; data1 = 8'(8'h30 + k); tick();
    end
    chk("rr_end", 1, 64'(ptr1), 64'(2));
    oready1 = 5'h1B;
    for (int k = 0; k < 7; k++) begin
      data1 = 8'(8'h50 + k); tick();
    end
    chk("rr_stall", 1, 64'(ptr1), 64'(2));
    chk("rr_stall_ready", 1, 64'(ready1), 64'(0));
    idle(); tick();

    // Out-of-range drops saturate.
    mode1 = 1'b0;
    for (int k = 0; k < 300; k++) begin
      valid1 = 1'b1; sel1 = 3'(5 + (k % 3)); data1 = 8'($urandom); tick();
    end
    chk("drop_sat", 1, 64'(drop1), 64'(255));
    idle(); tick();

    // Fill slots 1 and 6 with rr_ptr at 4, then pulse reset between edges.
    mode0 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      valid0 = 1'b1; data0 = 8'(8'h60 + k); tick();
    end
    idle(); tick();
    mode0 = 1'b0; oready0 = 8'h00; valid0 = 1'b1;
    sel0 = 3'd1; data0 = 8'h71; tick();
    sel0 = 3'd6; data0 = 8'h76; tick();
    chk("pre_rst_valid", 0, 64'(ovalid0), 64'(8'h42));
    chk("pre_rst_ptr", 0, 64'(ptr0), 64'(4));
    sel0 = 3'd2;
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", 0, 64'(ovalid0), 64'(0));
    chk("arst_ptr", 0, 64'(ptr0), 64'(0));
    chk("arst_drop", 1, 64'(drop1), 64'(0));
    chk("arst_ready", 0, 64'(ready0), 64'(0));
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    model_reset();
    idle();

    // Random traffic on both instances.
    for (int k = 0; k < 400; k++) begin
      mode0 = 1'($urandom); valid0 = 1'($urandom); sel0 = 3'($urandom);
      data0 = 8'($urandom); oready0 = 8'($urandom);
      mode1 = 1'($urandom); valid1 = 1'($urandom); sel1 = 3'($urandom_range(0, 7));
      data1 = 8'($urandom); oready1 = 5'($urandom);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
